// File: rtl/pid_control_gen.sv
// PID speed/turn controller for tracked-blob chasing and goalkeeping: errors, integrators and
// derivative-on-measurement at S0, products at S1, sum and saturation at S2 (latency 3).
module pid_control_gen #(
    parameter int DW      = 9,
    parameter int RW      = 7,
    parameter int GW      = 4,
    parameter int OW      = 9,
    parameter int SAT     = 255,
    parameter int IMAX    = 1023,
    parameter int ISHIFT  = 4,
    parameter int WIDTH   = 320,
    parameter int TIMEOUT = 2500000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic [DW-1:0]        cur_pos_x,
    input  logic [RW-1:0]        cur_rad,
    input  logic [RW-1:0]        goal_rad,
    input  logic [1:0]           mode,
    input  logic [GW-1:0]        ksp,
    input  logic [GW-1:0]        ksi,
    input  logic [GW-1:0]        ksd,
    input  logic [GW-1:0]        ktp,
    input  logic [GW-1:0]        kti,
    input  logic [GW-1:0]        ktd,
    output logic                 out_valid,
    output logic signed [OW-1:0] speed,
    output logic signed [OW-1:0] turn,
    output logic [1:0]           sat_flags,
    output logic                 lost
);

    localparam int MW   = (DW > RW) ? DW : RW;
    localparam int EW   = MW + 2;
    localparam int IW   = $clog2(IMAX + 1) + 1;
    localparam int OPW  = (EW > IW) ? EW : IW;
    localparam int IAW  = OPW + 1;
    localparam int PW   = OPW + GW + 1;
    localparam int SUMA = OW + GW + DW + 4;
    localparam int SUMW = (SUMA > PW + 2) ? SUMA : PW + 2;
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0]          XSET   = DW'(WIDTH >> 1);
    localparam logic signed [IAW-1:0]  IMAX_P = IAW'(IMAX);
    localparam logic signed [IAW-1:0]  IMAX_N = -IMAX_P;
    localparam logic signed [SUMW-1:0] SAT_P  = SUMW'(SAT);
    localparam logic signed [SUMW-1:0] SAT_N  = -SAT_P;

    function automatic logic signed [OPW-1:0] clamp_integ(input logic signed [IAW-1:0] v);
        if (v > IMAX_P) return IMAX_P[OPW-1:0];
        if (v < IMAX_N) return IMAX_N[OPW-1:0];
        return v[OPW-1:0];
    endfunction

    // Returns {clamped, value}.
    function automatic logic [OW:0] sat_out(input logic signed [SUMW-1:0] v);
        if (v > SAT_P) return {1'b1, SAT_P[OW-1:0]};
        if (v < SAT_N) return {1'b1, SAT_N[OW-1:0]};
        return {1'b0, v[OW-1:0]};
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [OPW-1:0] a,
                                                 input logic [GW-1:0]         k);
        return PW'(a) * PW'($signed({1'b0, k}));
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         prev_x_q, prev_x_d;
    logic [RW-1:0]         prev_r_q, prev_r_d;
    logic                  first_q, first_d;
    logic signed [OPW-1:0] ix_q, ix_d, ir_q, ir_d;
    logic [1:0]            mode_q, mode_d;
    logic                  lost_q, lost_d;

    logic                  mode_chg, first_eff, idle, chase, gkeep, to_evt;
    logic signed [OPW-1:0] ex_c, er_c, dx_c, dr_c, ix_base, ir_base, ix_new, ir_new;

    logic                  vld_p0_d, vld_p0_q;
    logic signed [OPW-1:0] se_d, si_d, sd_d, te_d, ti_d, td_d;
    logic signed [OPW-1:0] se_p0_q, si_p0_q, sd_p0_q, te_p0_q, ti_p0_q, td_p0_q;
    logic [GW-1:0]         ksp_p0_q, ksi_p0_q, ksd_p0_q, ktp_p0_q, kti_p0_q, ktd_p0_q;

    logic                  vld_p1_q;
    logic signed [PW-1:0]  sp_d, si_full, si_sh_d, sd_d1, tp_d, ti_full, ti_sh_d, td_d1;
    logic signed [PW-1:0]  sp_p1_q, si_p1_q, sd_p1_q, tp_p1_q, ti_p1_q, td_p1_q;

    logic signed [SUMW-1:0] spd_sum, trn_sum;
    logic signed [OW-1:0]   spd_sat, trn_sat;
    logic                   spd_flag, trn_flag;

    // ---- S0: errors, derivative on measurement, integrators, timeout ----
    always_comb begin
        mode_chg  = (mode != mode_q);
        first_eff = first_q | mode_chg;
        idle      = ~mode[1];
        chase     = (mode == 2'd2);
        gkeep     = (mode == 2'd3);

        ex_c = OPW'($signed({1'b0, XSET})) - OPW'($signed({1'b0, cur_pos_x}));
        er_c = OPW'($signed({1'b0, goal_rad})) - OPW'($signed({1'b0, cur_rad}));
        dx_c = first_eff ? '0
                         : OPW'($signed({1'b0, prev_x_q})) - OPW'($signed({1'b0, cur_pos_x}));
        dr_c = first_eff ? '0
                         : OPW'($signed({1'b0, prev_r_q})) - OPW'($signed({1'b0, cur_rad}));

        ix_base = mode_chg ? '0 : ix_q;
        ir_base = mode_chg ? '0 : ir_q;
        ix_new  = idle ? '0 : clamp_integ(IAW'(ix_base) + IAW'(ex_c));
        ir_new  = idle ? '0 : clamp_integ(IAW'(ir_base) + IAW'(er_c));

        // A sample arriving on the timeout cycle pre-empts the lost event.
        to_evt = ~ready_in & (cnt_q == CW'(TIMEOUT - 1));
        if (ready_in)                    cnt_d = '0;
        else if (cnt_q == CW'(TIMEOUT))  cnt_d = cnt_q;
        else                             cnt_d = cnt_q + CW'(1);

        prev_x_d = prev_x_q;
        prev_r_d = prev_r_q;
        first_d  = first_q;
        ix_d     = ix_q;
        ir_d     = ir_q;
        mode_d   = mode_q;
        lost_d   = lost_q;
        if (ready_in) begin
            prev_x_d = cur_pos_x;
            prev_r_d = cur_rad;
            first_d  = 1'b0;
            ix_d     = ix_new;
            ir_d     = ir_new;
            mode_d   = mode;
            lost_d   = 1'b0;
        end else if (to_evt) begin
            ix_d    = '0;
            ir_d    = '0;
            first_d = 1'b1;
            lost_d  = 1'b1;
        end

        // Idle samples and the lost event carry all-zero operands, so they yield 0/0, no flags.
        vld_p0_d = ready_in | to_evt;
        se_d = '0;
        si_d = '0;
        sd_d = '0;
        te_d = '0;
        ti_d = '0;
        td_d = '0;
        if (ready_in && chase) begin
            se_d = er_c;
            si_d = ir_new;
            sd_d = dr_c;
            te_d = ex_c;
            ti_d = ix_new;
            td_d = dx_c;
        end else if (ready_in && gkeep) begin
            se_d = ex_c;
            si_d = ix_new;
            sd_d = dx_c;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            prev_x_q  <= '0;
            prev_r_q  <= '0;
            first_q   <= 1'b1;
            ix_q      <= '0;
            ir_q      <= '0;
            mode_q    <= '0;
            lost_q    <= 1'b0;
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            out_valid <= 1'b0;
            speed     <= '0;
            turn      <= '0;
            sat_flags <= '0;
        end else begin
            cnt_q     <= cnt_d;
            prev_x_q  <= prev_x_d;
            prev_r_q  <= prev_r_d;
            first_q   <= first_d;
            ix_q      <= ix_d;
            ir_q      <= ir_d;
            mode_q    <= mode_d;
            lost_q    <= lost_d;
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p0_q;
            out_valid <= vld_p1_q;
            if (vld_p1_q) begin
                speed     <= spd_sat;
                turn      <= trn_sat;
                sat_flags <= {spd_flag, trn_flag};
            end
        end
    end

    assign lost = lost_q;

    // ---- S1: full-width signed products ----
    always_comb begin
        sp_d    = mul(se_p0_q, ksp_p0_q);
        si_full = mul(si_p0_q, ksi_p0_q);
        si_sh_d = si_full >>> ISHIFT;
        sd_d1   = mul(sd_p0_q, ksd_p0_q);
        tp_d    = mul(te_p0_q, ktp_p0_q);
        ti_full = mul(ti_p0_q, kti_p0_q);
        ti_sh_d = ti_full >>> ISHIFT;
        td_d1   = mul(td_p0_q, ktd_p0_q);
    end

    // ---- S2: wide sums and output saturation ----
    always_comb begin
        spd_sum = SUMW'(sp_p1_q) + SUMW'(si_p1_q) + SUMW'(sd_p1_q);
        trn_sum = SUMW'(tp_p1_q) + SUMW'(ti_p1_q) + SUMW'(td_p1_q);
        {spd_flag, spd_sat} = sat_out(spd_sum);
        {trn_flag, trn_sat} = sat_out(trn_sum);
    end

    always_ff @(posedge clk_in) begin
        if (vld_p0_d) begin
            se_p0_q  <= se_d;
            si_p0_q  <= si_d;
            sd_p0_q  <= sd_d;
            te_p0_q  <= te_d;
            ti_p0_q  <= ti_d;
            td_p0_q  <= td_d;
            ksp_p0_q <= ksp;
            ksi_p0_q <= ksi;
            ksd_p0_q <= ksd;
            ktp_p0_q <= ktp;
            kti_p0_q <= kti;
            ktd_p0_q <= ktd;
        end
        if (vld_p0_q) begin
            sp_p1_q <= sp_d;
            si_p1_q <= si_sh_d;
            sd_p1_q <= sd_d1;
            tp_p1_q <= tp_d;
            ti_p1_q <= ti_sh_d;
            td_p1_q <= td_d1;
        end
    end

endmodule

// File: tb/tb_pid_control_gen.sv
// Bench for pid_control_gen: directed scenarios plus randomized traffic checked every cycle
// against a per-sample arithmetic PID model with a 3-cycle result delay.
module tb_pid_control_gen;

    localparam int DW = 9, RW = 7, GW = 4, OW = 9, SAT = 255;
    localparam int IMAX = 50, ISHIFT = 1, WIDTH = 320, TIMEOUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, ready;
    logic [DW-1:0]        x;
    logic [RW-1:0]        r, g;
    logic [1:0]           md;
    logic [GW-1:0]        ksp, ksi, ksd, ktp, kti, ktd;
    logic                 out_valid, lost;
    logic signed [OW-1:0] speed, turn;
    logic [1:0]           sat_flags;

    pid_control_gen #(.DW(DW), .RW(RW), .GW(GW), .OW(OW), .SAT(SAT), .IMAX(IMAX),
                      .ISHIFT(ISHIFT), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk), .rst_in(rst), .ready_in(ready), .cur_pos_x(x), .cur_rad(r),
        .goal_rad(g), .mode(md), .ksp(ksp), .ksi(ksi), .ksd(ksd), .ktp(ktp), .kti(kti),
        .ktd(ktd), .out_valid(out_valid), .speed(speed), .turn(turn),
        .sat_flags(sat_flags), .lost(lost)
    );

    int ncmp = 0, nfail = 0, cyc = 0;

    // Reference model state
    int m_px, m_pr, m_ix, m_ir, m_mode, m_since;
    bit m_first, m_lost;
    bit rv[4];
    int rs[4], rt[4], rf[4];
    int h_s, h_t, h_f;
    bit ev_now;
    int t4[5] = '{20, 40, 50, 50, 50};

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int clampi(int v, int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int pid(int e, int i, int d, int kp, int ki, int kd);
        return kp * e + ((ki * i) >>> ISHIFT) + kd * d;
    endfunction

    task automatic model_sample(input int s);
        int ex, er, dx, dr, sp, tu;
        bit chg, f;
        chg = (int'(md) != m_mode);
        f   = m_first || chg;
        if (chg) begin m_ix = 0; m_ir = 0; end
        ex = WIDTH / 2 - int'(x);
        er = int'(g) - int'(r);
        dx = f ? 0 : m_px - int'(x);
        dr = f ? 0 : m_pr - int'(r);
        sp = 0;
        tu = 0;
        if (md < 2) begin
            m_ix = 0;
            m_ir = 0;
        end else begin
            m_ix = clampi(m_ix + ex, IMAX);
            m_ir = clampi(m_ir + er, IMAX);
            if (md == 2) begin
                sp = pid(er, m_ir, dr, int'(ksp), int'(ksi), int'(ksd));
                tu = pid(ex, m_ix, dx, int'(ktp), int'(kti), int'(ktd));
            end else begin
                sp = pid(ex, m_ix, dx, int'(ksp), int'(ksi), int'(ksd));
            end
        end
        rv[s] = 1'b1;
        rs[s] = clampi(sp, SAT);
        rt[s] = clampi(tu, SAT);
        rf[s] = ((sp > SAT || sp < -SAT) ? 2 : 0) + ((tu > SAT || tu < -SAT) ? 1 : 0);
        m_px = int'(x);
        m_pr = int'(r);
        m_first = 1'b0;
        m_mode = int'(md);
        m_lost = 1'b0;
    endtask

    task automatic model_edge();
        int slot, nxt;
        slot = cyc % 4;
        nxt  = (cyc + 2) % 4;
        if (rst) begin
            m_px = 0; m_pr = 0; m_ix = 0; m_ir = 0; m_mode = 0; m_since = 0;
            m_first = 1'b1; m_lost = 1'b0;
            for (int i = 0; i < 4; i++) rv[i] = 1'b0;
            h_s = 0; h_t = 0; h_f = 0;
            ev_now = 1'b0;
        end else begin
            ev_now = rv[slot];
            if (rv[slot]) begin h_s = rs[slot]; h_t = rt[slot]; h_f = rf[slot]; end
            rv[slot] = 1'b0;
            if (ready) begin
                model_sample(nxt);
                m_since = 0;
            end else begin
                if (m_since == TIMEOUT - 1) begin
                    m_ix = 0; m_ir = 0; m_first = 1'b1; m_lost = 1'b1;
                    rv[nxt] = 1'b1; rs[nxt] = 0; rt[nxt] = 0; rf[nxt] = 0;
                end
                if (m_since < TIMEOUT) m_since++;
            end
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, ev_now);
        chk("lost", lost, m_lost);
        chk("speed", speed, h_s);
        chk("turn", turn, h_t);
        chk("sat_flags", sat_flags, h_f);
        cyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc_step();
        cyc_step();
        rst = 1'b0;
    endtask

    task automatic sample(input int m, input int xx, input int rr, input int gg);
        ready = 1'b1;
        md = 2'(m);
        x  = DW'(xx);
        r  = RW'(rr);
        g  = RW'(gg);
        cyc_step();
        ready = 1'b0;
    endtask

    task automatic set_gains(input int a, input int b, input int c,
                             input int d, input int e, input int f);
        ksp = GW'(a); ksi = GW'(b); ksd = GW'(c);
        ktp = GW'(d); kti = GW'(e); ktd = GW'(f);
    endtask

    initial begin
        int gap;
        gap = 0;
        rst = 1'b1; ready = 1'b0; x = '0; r = '0; g = '0; md = '0;
        set_gains(0, 0, 0, 0, 0, 0);

        // Reset state
        reset_dut();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_speed", speed, 0);
        chk("rst_lost", lost, 0);

        // Goalkeep P-only, latency 3
        set_gains(2, 0, 0, 0, 0, 0);
        sample(3, 100, 0, 0);
        cyc_step();
        chk("t1_early", out_valid, 0);
        cyc_step();
        chk("t1_valid", out_valid, 1);
        chk("t1_speed", speed, 120);
        chk("t1_turn", turn, 0);
        cyc_step();
        chk("t1_pulse", out_valid, 0);
        chk("t1_hold", speed, 120);

        // Chase turn with derivative suppressed on the first sample
        reset_dut();
        set_gains(0, 0, 0, 2, 0, 1);
        sample(2, 200, 0, 0);
        sample(2, 190, 0, 0);
        cyc_step();
        chk("t2_turn_first", turn, -80);
        cyc_step();
        chk("t2_turn_d", turn, -50);

        // Speed saturation and flag
        reset_dut();
        set_gains(15, 0, 0, 0, 0, 0);
        sample(2, 160, 0, 100);
        sample(2, 160, 100, 100);
        cyc_step();
        chk("t3_speed_sat", speed, 255);
        chk("t3_flags_sat", sat_flags, 2);
        cyc_step();
        chk("t3_speed_zero", speed, 0);
        chk("t3_flags_zero", sat_flags, 0);

        // Integrator anti-windup at IMAX
        reset_dut();
        set_gains(0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            sample(3, 140, 0, 0);
            if (i >= 2) chk("t4_integ", speed, t4[i-2]);
        end
        cyc_step();
        chk("t4_integ", speed, t4[3]);
        cyc_step();
        chk("t4_integ", speed, t4[4]);

        // Lost-target timeout: 8 cycles without ready_in since the last sample
        for (int i = 0; i < 5; i++) cyc_step();
        chk("t5_not_lost", lost, 0);
        cyc_step();
        chk("t5_lost", lost, 1);
        cyc_step();
        chk("t5_no_vld_yet", out_valid, 0);
        cyc_step();
        chk("t5_vld", out_valid, 1);
        chk("t5_speed", speed, 0);
        chk("t5_turn", turn, 0);
        cyc_step();
        chk("t5_one_pulse", out_valid, 0);
        chk("t5_still_lost", lost, 1);
        sample(3, 140, 0, 0);
        chk("t5_recover", lost, 0);
        cyc_step();
        cyc_step();
        chk("t5_integ_cleared", speed, 20);

        // Back-to-back throughput, then reset mid-flight
        reset_dut();
        set_gains(3, 5, 2, 4, 7, 1);
        for (int i = 0; i < 4; i++) begin
            sample(2, $urandom_range(0, 511), $urandom_range(0, 127), $urandom_range(0, 127));
            if (i >= 2) chk("t6_b2b", out_valid, 1);
        end
        cyc_step();
        chk("t6_b2b", out_valid, 1);
        cyc_step();
        chk("t6_b2b", out_valid, 1);
        sample(2, 10, 20, 30);
        sample(2, 300, 5, 90);
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_step();
            chk("t6_flush", out_valid, 0);
        end

        // Randomized traffic
        reset_dut();
        md = 2'd2;
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0)
                set_gains($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            if (gap > 0) begin
                ready = 1'b0;
                gap--;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) gap = $urandom_range(6, 12);
            end
            x = DW'($urandom_range(0, 511));
            r = RW'($urandom_range(0, 127));
            g = RW'($urandom_range(0, 127));
            cyc_step();
        end
        rst = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc_step();

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
